// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the UART transmitter: the bus side writes bytes, and a
// two-state launcher hands them one at a time to the core via TX_start/TX_done.
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              ovf_clr,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              tx_busy,
  output logic              TX_start,
  output logic [7:0]        TX_data,
  input  logic              TX_done
);

  // Handshake: TX_start is a one-cycle launch with TX_data held stable until
  // the core answers with a one-cycle TX_done; a TX_done while idle is ignored.
  // The bus side has no backpressure: a write while full is dropped and flagged.

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  state_t            state;
  state_t            state_next;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_next;
  logic              push;
  logic              pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push    = wr_en && !full;
  // The FSM state register is the busy flag, so tx_busy doubles as the state view.
  assign tx_busy = (state == ST_WAIT);

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (TX_done) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + (ADDR_W + 1)'(1);
      2'b01:   count_next = count - (ADDR_W + 1)'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      TX_start <= 1'b0;
      TX_data  <= 8'h00;
    end else begin
      state    <= state_next;
      count    <= count_next;
      TX_start <= pop;
      if (push) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + ADDR_W'(1);
        TX_data <= mem[rd_ptr];
      end
      // Set wins over clear; full is the pre-pop value, so a launch does not save the byte.
      if (wr_en && full) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: queue-based reference model, a byte
// scoreboard on every TX_start, and one task per scenario.
module tb_uart_tx_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clock;
  logic              reset;
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              ovf_clr;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              tx_busy;
  logic              TX_start;
  logic [7:0]        TX_data;
  logic              TX_done;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [7:0] m_q[$];
  logic       m_busy;
  logic       m_start;
  logic [7:0] m_data;
  logic       m_ovf;
  logic [7:0] exp_q[$];
  logic       prev_start;
  logic [7:0] exp_b;

  logic [17:0] dut_vec;
  assign dut_vec = {count, full, empty, overflow, tx_busy, TX_start, TX_data};

  uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .ovf_clr  (ovf_clr),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .tx_busy  (tx_busy),
    .TX_start (TX_start),
    .TX_data  (TX_data),
    .TX_done  (TX_done)
  );

  // clock / reset block
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    reset   = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    ovf_clr = 1'b0;
    TX_done = 1'b0;
  end

  function automatic logic [17:0] model_vec();
    int sz;
    sz = m_q.size();
    return {(ADDR_W + 1)'(sz), sz == DEPTH, sz == 0, m_ovf, m_busy, m_start, m_data};
  endfunction

  task automatic model_reset();
    m_q.delete();
    exp_q.delete();
    m_busy  = 1'b0;
    m_start = 1'b0;
    m_data  = 8'h00;
    m_ovf   = 1'b0;
  endtask

  // driver: one clock cycle with the given inputs, model advanced at the edge,
  // returns 1 time unit after the edge so outputs can be sampled
  task automatic drive_cycle(input logic we, input logic [7:0] wd,
                             input logic oc, input logic done);
    logic full_b;
    logic launch;
    @(negedge clock);
    wr_en   = we;
    wr_data = wd;
    ovf_clr = oc;
    TX_done = done;
    @(posedge clock);
    full_b  = (m_q.size() == DEPTH);
    launch  = !m_busy && (m_q.size() != 0);
    if (m_busy && done) m_busy = 1'b0;
    m_start = 1'b0;
    if (launch) begin
      m_data  = m_q.pop_front();
      m_busy  = 1'b1;
      m_start = 1'b1;
    end
    if (we && !full_b) begin
      m_q.push_back(wd);
      exp_q.push_back(wd);
    end
    if (we && full_b) m_ovf = 1'b1;
    else if (oc) m_ovf = 1'b0;
    #1;
    wr_en   = 1'b0;
    ovf_clr = 1'b0;
    TX_done = 1'b0;
  endtask

  // acknowledge launched bytes until the FIFO is empty and idle
  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (count == '0 && !tx_busy) begin
        ok = 1'b1;
        break;
      end
      drive_cycle(1'b0, 8'h00, 1'b0, tx_busy && ($urandom_range(0, 2) != 0));
    end
  endtask

  // scoreboard: every launched byte must be the next accepted byte
  initial prev_start = 1'b0;
  always @(negedge clock) begin
    if (reset && TX_start) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL tx_order: launched %h but no byte was expected", TX_data);
      end else begin
        exp_b = exp_q.pop_front();
        if (TX_data !== exp_b) begin
          n_fail++;
          $display("FAIL tx_order: TX_data=%h expected=%h", TX_data, exp_b);
        end
      end
      n_checks++;
      if (prev_start) begin
        n_fail++;
        $display("FAIL tx_start_repeat: TX_start high two cycles running, got 1 expected 0");
      end
    end
    prev_start = reset && TX_start;
  end

  task automatic test_reset();
    model_reset();
    repeat (2) @(posedge clock);
    #2;
    n_checks++;
    if (dut_vec !== {5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_values: got %h expected %h", dut_vec,
               {5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    end
    @(negedge clock);
    reset = 1'b1;
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
    n_checks++;
    if (dut_vec !== model_vec()) begin
      n_fail++;
      $display("FAIL reset_release: got %h expected %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_single_byte();
    drive_cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    n_checks++;
    if (count !== 5'd1 || TX_start !== 1'b0) begin
      n_fail++;
      $display("FAIL single_write: count=%0d start=%b expected count=1 start=0", count, TX_start);
    end
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
    n_checks++;
    if (TX_start !== 1'b1 || TX_data !== 8'hA5 || count !== 5'd0 || tx_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_launch: start=%b data=%h count=%0d busy=%b expected 1 a5 0 1",
               TX_start, TX_data, count, tx_busy);
    end
    for (int i = 0; i < 19; i++) begin
      drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("FAIL single_wait: got %h expected %h", dut_vec, model_vec());
      end
    end
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
      n_checks++;
      if (tx_busy !== 1'b0 || TX_start !== 1'b0 || TX_data !== 8'hA5) begin
        n_fail++;
        $display("FAIL single_done: busy=%b start=%b data=%h expected 0 0 a5",
                 tx_busy, TX_start, TX_data);
      end
    end
  endtask

  task automatic test_burst();
    int nb;
    int cyc;
    int last;
    for (int i = 1; i <= 16; i++) drive_cycle(1'b1, 8'(i), 1'b0, 1'b0);
    n_checks++;
    if (count !== 5'd15 || full !== 1'b0 || tx_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL burst_count: count=%0d full=%b busy=%b expected 15 0 1", count, full, tx_busy);
    end
    drive_cycle(1'b1, 8'h11, 1'b0, 1'b0);
    n_checks++;
    if (full !== 1'b1 || count !== 5'd16) begin
      n_fail++;
      $display("FAIL burst_full: full=%b count=%0d expected 1 16", full, count);
    end
    nb   = 2;
    cyc  = 0;
    last = 0;
    while (nb <= 17 && cyc < 200) begin
      drive_cycle(1'b0, 8'h00, 1'b0, tx_busy);
      cyc++;
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("FAIL burst_model: got %h expected %h", dut_vec, model_vec());
      end
      if (TX_start) begin
        n_checks++;
        if (TX_data !== 8'(nb)) begin
          n_fail++;
          $display("FAIL burst_order: data=%h expected=%h", TX_data, 8'(nb));
        end
        if (nb > 2) begin
          n_checks++;
          if (cyc - last !== 2) begin
            n_fail++;
            $display("FAIL burst_gap: start spacing=%0d expected 2", cyc - last);
          end
        end
        last = cyc;
        nb++;
      end
    end
    n_checks++;
    if (nb != 18) begin
      n_fail++;
      $display("FAIL burst_timeout: drained %0d bytes expected 16", nb - 2);
    end
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    n_checks++;
    if (tx_busy !== 1'b0 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL burst_end: busy=%b empty=%b expected 0 1", tx_busy, empty);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    for (int i = 0; i < 17; i++) drive_cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    drive_cycle(1'b1, 8'hFF, 1'b0, 1'b0);
    n_checks++;
    if (overflow !== 1'b1 || count !== 5'd16 || full !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set: ovf=%b count=%0d full=%b expected 1 16 1", overflow, count, full);
    end
    drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clr: ovf=%b expected 0", overflow);
    end
    drive_cycle(1'b1, 8'hFF, 1'b1, 1'b0);
    n_checks++;
    if (overflow !== 1'b1 || count !== 5'd16) begin
      n_fail++;
      $display("FAIL ovf_set_wins: ovf=%b count=%0d expected 1 16", overflow, count);
    end
    drive_cycle(1'b0, 8'h00, 1'b1, 1'b1);
    drive_cycle(1'b1, 8'hFE, 1'b0, 1'b0);
    n_checks++;
    if (overflow !== 1'b1 || count !== 5'd15 || TX_start !== 1'b1 || TX_data !== 8'h21) begin
      n_fail++;
      $display("FAIL ovf_pop_same_cycle: ovf=%b count=%0d start=%b data=%h expected 1 15 1 21",
               overflow, count, TX_start, TX_data);
    end
    drain(ok);
    n_checks++;
    if (!ok || dut_vec !== model_vec()) begin
      n_fail++;
      $display("FAIL ovf_drain: got %h expected %h ok=%0d", dut_vec, model_vec(), ok);
    end
    drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_simultaneous();
    bit ok;
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    n_checks++;
    if (count !== 5'd3 || tx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_setup: count=%0d busy=%b expected 3 0", count, tx_busy);
    end
    drive_cycle(1'b1, 8'h34, 1'b0, 1'b0);
    n_checks++;
    if (count !== 5'd3 || TX_start !== 1'b1 || TX_data !== 8'h31) begin
      n_fail++;
      $display("FAIL simul_push_pop: count=%0d start=%b data=%h expected 3 1 31",
               count, TX_start, TX_data);
    end
    for (int i = 0; i < 40; i++) begin
      drive_cycle(1'(($urandom_range(0, 3) != 0)), 8'($urandom), 1'(($urandom_range(0, 7) == 0)),
                  tx_busy && ($urandom_range(0, 2) == 0));
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("FAIL simul_mixed[%0d]: got %h expected %h", i, dut_vec, model_vec());
      end
    end
    drain(ok);
    n_checks++;
    if (!ok || dut_vec !== model_vec()) begin
      n_fail++;
      $display("FAIL simul_drain: got %h expected %h ok=%0d", dut_vec, model_vec(), ok);
    end
    drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_spurious_done();
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
      n_checks++;
      if (TX_start !== 1'b0 || tx_busy !== 1'b0 || count !== 5'd0 || empty !== 1'b1) begin
        n_fail++;
        $display("FAIL spurious_done: start=%b busy=%b count=%0d empty=%b expected 0 0 0 1",
                 TX_start, tx_busy, count, empty);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) drive_cycle(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
    n_checks++;
    if (count !== 5'd5 || tx_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_setup: count=%0d busy=%b expected 5 1", count, tx_busy);
    end
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (dut_vec !== {5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL rst_mid_async: got %h expected %h", dut_vec,
               {5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
      n_checks++;
      if (TX_start !== 1'b0 || dut_vec !== model_vec()) begin
        n_fail++;
        $display("FAIL rst_mid_quiet: got %h expected %h", dut_vec, model_vec());
      end
    end
    drive_cycle(1'b1, 8'hAB, 1'b0, 1'b0);
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
    n_checks++;
    if (TX_start !== 1'b1 || TX_data !== 8'hAB || count !== 5'd0) begin
      n_fail++;
      $display("FAIL rst_mid_relaunch: start=%b data=%h count=%0d expected 1 ab 0",
               TX_start, TX_data, count);
    end
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_burst();
    test_overflow();
    test_simultaneous();
    test_spurious_done();
    test_reset_mid();
    repeat (2) @(posedge clock);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL final_scoreboard: %0d bytes never launched, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
